// File: rtl/stg4mo_ctrl_if.sv
// ---------------------------------------------------------------------------
// stg4mo_ctrl_if
//   Data-memory request/acknowledge bus used by the stage-4 memory sequencer.
//   The sequencer is the master: it raises a request with address, write
//   enable and write data, and the memory answers with an acknowledge and,
//   for loads, read data in the same cycle.
//
//   Signals:
//     ow_mem_req    master -> slave  request active
//     ow_mem_we     master -> slave  1 = write, 0 = read
//     ow_mem_addr   master -> slave  word address (`SIZE_ADDR bits)
//     ow_mem_wdata  master -> slave  store data (`SIZE_DATA bits)
//     iw_mem_ack    slave  -> master request completes this cycle
//     iw_mem_rdata  slave  -> master read data, valid with iw_mem_ack
// ---------------------------------------------------------------------------
`ifndef SIZE_DATA
`define SIZE_DATA 16
`endif
`ifndef SIZE_ADDR
`define SIZE_ADDR 12
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 3
`endif

interface stg4mo_ctrl_if;
    logic                   ow_mem_req;
    logic                   ow_mem_we;
    logic [`SIZE_ADDR-1:0]  ow_mem_addr;
    logic [`SIZE_DATA-1:0]  ow_mem_wdata;
    logic                   iw_mem_ack;
    logic [`SIZE_DATA-1:0]  iw_mem_rdata;

    modport master (
        output ow_mem_req,
        output ow_mem_we,
        output ow_mem_addr,
        output ow_mem_wdata,
        input  iw_mem_ack,
        input  iw_mem_rdata
    );

    modport slave (
        input  ow_mem_req,
        input  ow_mem_we,
        input  ow_mem_addr,
        input  ow_mem_wdata,
        output iw_mem_ack,
        output iw_mem_rdata
    );
endinterface

// File: rtl/stg4mo_ctrl.sv
// ---------------------------------------------------------------------------
// stg4mo_ctrl
//   Memory-access sequencer for pipeline stage 4. Non-memory ops pass through
//   with one cycle of latency; loads and stores become a single req/ack
//   transaction on the data-memory bus while upstream is stalled. Produces
//   the valid/result/target triple latched by stg4mo.
//
//   Optional feature macro: MEMCTRL_TIMEOUT_EN
//     defined   -> bus timeout after P_TIMEOUT BUSY cycles without ack,
//                  followed by a one-cycle ow_err pulse
//     undefined -> BUSY waits for ack indefinitely, ow_err tied 0
//
//   Ports:
//     iw_clk, iw_rst         clock, asynchronous active-high reset
//     iw_valid               stage-3 presents an op
//     iw_mem_rd / iw_mem_wr  op is a load / store
//     iw_result              ALU result, or address for loads/stores
//     iw_wdata               store data
//     iw_tgt_gp              GP write target (0 = none)
//     ow_stall               upstream must hold its outputs
//     bus                    data-memory bus (master side)
//     ow_valid/ow_result/ow_tgt_gp  result toward stg4mo
//     ow_err                 one-cycle pulse after a bus timeout
// ---------------------------------------------------------------------------
`ifndef SIZE_DATA
`define SIZE_DATA 16
`endif
`ifndef SIZE_ADDR
`define SIZE_ADDR 12
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 3
`endif

module stg4mo_ctrl
`ifdef MEMCTRL_TIMEOUT_EN
#(
    parameter int P_TIMEOUT = 15,
    parameter int P_TMO_W   = 4
)
`endif
(
    input  logic                     iw_clk,
    input  logic                     iw_rst,
    input  logic                     iw_valid,
    input  logic                     iw_mem_rd,
    input  logic                     iw_mem_wr,
    input  logic [`SIZE_DATA-1:0]    iw_result,
    input  logic [`SIZE_DATA-1:0]    iw_wdata,
    input  logic [`SIZE_TGT_GP-1:0]  iw_tgt_gp,
    output logic                     ow_stall,
    stg4mo_ctrl_if.master            bus,
    output logic                     ow_valid,
    output logic [`SIZE_DATA-1:0]    ow_result,
    output logic [`SIZE_TGT_GP-1:0]  ow_tgt_gp,
    output logic                     ow_err
);

    localparam int DW = `SIZE_DATA;
    localparam int AW = `SIZE_ADDR;
    localparam int TW = `SIZE_TGT_GP;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [TW-1:0]   r_tgt;

    logic            r_valid;
    logic [DW-1:0]   r_result;
    logic [TW-1:0]   r_tgt_out;

    logic            w_valid_nxt;
    logic [DW-1:0]   w_result_nxt;
    logic [TW-1:0]   w_tgt_nxt;

    logic            w_accept;
    logic            w_ack;
    logic            w_timeout;
    logic [DW-1:0]   w_addr_ext;

    // A memory op is only accepted from IDLE; while BUSY the stage-3 inputs
    // are held by the stall and must not be looked at.
    assign w_accept   = (r_state == S_IDLE) && iw_valid && (iw_mem_rd || iw_mem_wr);
    // An ack only counts while our request is actually up.
    assign w_ack      = (r_state == S_BUSY) && bus.iw_mem_ack;
    assign w_addr_ext = DW'(r_addr);

`ifdef MEMCTRL_TIMEOUT_EN
    logic [P_TMO_W-1:0] r_tmo;
    logic               r_err;

    // The counter holds the number of completed BUSY cycles without ack, so
    // the P_TIMEOUT-th such cycle is the one where it equals P_TIMEOUT-1.
    // An ack in that same cycle takes priority over the timeout.
    assign w_timeout = (r_state == S_BUSY) && !bus.iw_mem_ack &&
                       (r_tmo == P_TMO_W'(P_TIMEOUT - 1));

    // Timeout counter and the error pulse that follows an abort.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_accept)
                r_tmo <= '0;
            else if ((r_state == S_BUSY) && !bus.iw_mem_ack)
                r_tmo <= r_tmo + P_TMO_W'(1);
        end
    end

    assign ow_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign ow_err    = 1'b0;
`endif

    // State register.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept)            w_state_nxt = S_BUSY;
            S_BUSY: if (w_ack || w_timeout)  w_state_nxt = S_IDLE;
            default:                         w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: the result triple presented to stg4mo one cycle later.
    // A store completes with its zero-extended address as the result and no
    // GP target; a timeout completes with an all-zero result.
    always_comb begin
        w_valid_nxt  = 1'b0;
        w_result_nxt = '0;
        w_tgt_nxt    = '0;
        case (r_state)
            S_IDLE: begin
                if (iw_valid && !(iw_mem_rd || iw_mem_wr)) begin
                    w_valid_nxt  = 1'b1;
                    w_result_nxt = iw_result;
                    w_tgt_nxt    = iw_tgt_gp;
                end
            end
            S_BUSY: begin
                if (w_ack) begin
                    w_valid_nxt = 1'b1;
                    if (r_we) begin
                        w_result_nxt = w_addr_ext;
                    end else begin
                        w_result_nxt = bus.iw_mem_rdata;
                        w_tgt_nxt    = r_tgt;
                    end
                end else if (w_timeout) begin
                    w_valid_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Stall and request come straight from the registered state, so there
    // is never a combinational path from iw_mem_ack back to upstream.
    assign ow_stall         = (r_state == S_BUSY);
    assign bus.ow_mem_req   = (r_state == S_BUSY);
    assign bus.ow_mem_we    = r_we;
    assign bus.ow_mem_addr  = r_addr;
    assign bus.ow_mem_wdata = r_wdata;

    // The latched op only changes on acceptance, which keeps the bus
    // address/data/we stable for the whole transaction.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_tgt   <= '0;
        end else if (w_accept) begin
            r_we    <= iw_mem_wr;
            r_addr  <= iw_result[AW-1:0];
            r_wdata <= iw_wdata;
            r_tgt   <= iw_tgt_gp;
        end
    end

    // Registered result triple toward stg4mo.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_tgt_out <= '0;
        end else begin
            r_valid   <= w_valid_nxt;
            r_result  <= w_result_nxt;
            r_tgt_out <= w_tgt_nxt;
        end
    end

    assign ow_valid  = r_valid;
    assign ow_result = r_result;
    assign ow_tgt_gp = r_tgt_out;

endmodule

// File: doc/stg4mo_ctrl.md
Name: stg4mo_ctrl

Overview:
- Memory-access sequencer for pipeline stage 4; sits between the stage-3 outputs and the stg4mo latch.
- Non-memory ops pass through with one cycle of latency.
- Loads and stores are issued as a req/ack transaction to the data memory. Upstream stages are stalled until the transaction completes.
- Produces the valid/result/target triple that stg4mo latches.

Parameters:
P_TIMEOUT, 15, max cycles to wait for iw_mem_ack before aborting (only with timeout feature)
P_TMO_W, 4, width of timeout counter; must satisfy 2^P_TMO_W > P_TIMEOUT

Ports:
iw_clk  in  1  clock
iw_rst  in  1  asynchronous reset, active-high
iw_valid  in  1  stage-3 presents an op this cycle
iw_mem_rd  in  1  op is a load
iw_mem_wr  in  1  op is a store (never both with iw_mem_rd)
iw_result  in  `SIZE_DATA  ALU result; memory address for ld/st (low `SIZE_ADDR bits)
iw_wdata  in  `SIZE_DATA  store data
iw_tgt_gp  in  `SIZE_TGT_GP  GP write target (0 = none)
ow_stall  out  1  upstream must hold its outputs
ow_mem_req  out  1  memory request
ow_mem_we  out  1  1 = write
ow_mem_addr  out  `SIZE_ADDR  memory address
ow_mem_wdata  out  `SIZE_DATA  write data
iw_mem_ack  in  1  memory completes the request this cycle
iw_mem_rdata  in  `SIZE_DATA  read data, valid with iw_mem_ack
ow_valid  out  1  result valid toward stg4mo
ow_result  out  `SIZE_DATA  load data or pass-through result
ow_tgt_gp  out  `SIZE_TGT_GP  GP target
ow_err  out  1  one-cycle pulse on bus timeout

Behaviour:
- Reset (async): state IDLE. All outputs 0, including ow_mem_req, which drops immediately even mid-transaction. Latched op and timeout counter are cleared.
- States: IDLE, BUSY.
- ow_stall = (state == BUSY), registered-state based only; no combinational path from iw_mem_ack.
- IDLE, iw_valid=0: next cycle ow_valid=0, ow_tgt_gp=0.
- IDLE, iw_valid=1, no rd/wr: next cycle ow_valid=1, ow_result=iw_result, ow_tgt_gp=iw_tgt_gp. Stay IDLE.
- IDLE, iw_valid=1, rd or wr:
  - Latch address, wdata, we=iw_mem_wr, and target. Go to BUSY.
  - Next cycle: ow_mem_req=1, ow_valid=0.
- BUSY:
  - ow_mem_req=1. ow_mem_addr, ow_mem_we and ow_mem_wdata stay stable until ack.
  - Stage-3 inputs are ignored, because they are held by the stall.
- BUSY and iw_mem_ack=1: go to IDLE. Next cycle ow_mem_req=0 and ow_valid=1.
  - Load: ow_result=iw_mem_rdata, ow_tgt_gp=latched target.
  - Store: ow_result=address zero-extended, ow_tgt_gp=0.
- iw_mem_ack while ow_mem_req=0 is ignored.
- Latency:
  - Op accepted at cycle T: ow_mem_req is high from T+1.
  - Ack at cycle A: ow_valid at A+1; the next op is accepted at A+1.
  - Minimum load-to-result is 2 cycles (ack at T+1).
- Back-to-back ld/st: the second op is accepted in the IDLE cycle after the first completes. At most one outstanding request.

Optional Feature:
MEMCTRL_TIMEOUT_EN
- Defined:
  - Counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - If the counter reaches P_TIMEOUT without ack: go to IDLE and drop ow_mem_req.
  - Next cycle: ow_err=1 for one cycle, ow_valid=1, ow_tgt_gp=0, ow_result=0.
  - An ack in the same cycle as the timeout wins; no error is raised.
- Undefined: no counter. BUSY waits indefinitely; ow_err is tied 0.

Test Plan:
- Reset, then iw_valid=1 with no mem op, iw_result=0x00A5, iw_tgt_gp=3 -> next cycle ow_valid=1, ow_result=0x00A5, ow_tgt_gp=3, ow_stall=0.
- Load at address 0x0040 with tgt 5, ack after 3 BUSY cycles with rdata 0x1234:
  - ow_stall=1 and ow_mem_req=1 for those 3 cycles, plus the ack cycle.
  - Next cycle: ow_valid=1, ow_result=0x1234, ow_tgt_gp=5.
- Store: addr 0x0010, wdata 0x00FF, ack on the first BUSY cycle -> ow_mem_we=1, ow_mem_wdata=0x00FF; next cycle ow_valid=1, ow_tgt_gp=0.
- Load immediately followed by an ALU op held under stall -> ALU result appears the cycle after the load result; no op is lost or duplicated.
- With MEMCTRL_TIMEOUT_EN and P_TIMEOUT=15, no ack -> req drops after 15 BUSY cycles, then ow_err pulses once with ow_valid=1, ow_tgt_gp=0. A repeat run with ack at exactly the timeout cycle gives no error.
- Assert iw_rst mid-BUSY -> ow_mem_req and ow_stall go 0 asynchronously; after release, the first op behaves as from a clean reset.
